// File: rtl/video_cfg_ctrl.sv
// Button-driven video configuration: synchronise and debounce the buttons, stage
// pattern/brightness/blank changes in shadow registers, and commit them at a frame boundary.
module video_cfg_ctrl #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int FRAME_TIMEOUT   = 2000000,
  parameter int NUM_PATTERNS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       frame_start,
  output logic [2:0] pattern_sel,
  output logic [3:0] brightness,
  output logic       blank,
  output logic       cfg_update,
  output logic       pending
);

  // state   | meaning
  // IDLE    | committed outputs match shadow, nothing waiting
  // PENDING | shadow changed, waiting for frame_start or the timeout
  // COMMIT  | one cycle: shadow copied to outputs on the closing edge

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  localparam int             DW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0]  DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam int             TW       = $clog2(FRAME_TIMEOUT) + 1;
  // Down-counter loaded so the commit lands FRAME_TIMEOUT+1 cycles after the event.
  localparam logic [TW-1:0]  TO_LOAD  = (FRAME_TIMEOUT >= 2) ? TW'(FRAME_TIMEOUT - 2) : '0;
  localparam logic [2:0]     PAT_LAST = 3'(NUM_PATTERNS - 1);

  logic [3:0]    sync1, sync2, deb, deb_d;
  logic [DW-1:0] db_cnt [4];
  logic [3:0]    ev;
  logic          any_ev;

  logic [2:0]    shd_pat, shd_pat_nxt;
  logic [3:0]    shd_bri, shd_bri_nxt;
  logic          shd_blank, shd_blank_nxt;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  assign ev      = deb & ~deb_d;
  assign any_ev  = |ev;
  assign pending = (state != IDLE);

  always_comb begin
    shd_pat_nxt   = shd_pat;
    shd_bri_nxt   = shd_bri;
    shd_blank_nxt = shd_blank;
    case (ev[1:0])
      2'b01:   shd_pat_nxt = (shd_pat == PAT_LAST) ? 3'd0 : shd_pat + 3'd1;
      2'b10:   shd_pat_nxt = (shd_pat == 3'd0) ? PAT_LAST : shd_pat - 3'd1;
      2'b11:   shd_blank_nxt = ~shd_blank;
      default: ;
    endcase
    case (ev[3:2])
      2'b01:   shd_bri_nxt = (shd_bri == 4'd15) ? 4'd15 : shd_bri + 4'd1;
      2'b10:   shd_bri_nxt = (shd_bri == 4'd0) ? 4'd0 : shd_bri - 4'd1;
      2'b11:   shd_bri_nxt = 4'd8;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        if (any_ev) begin
          state_nxt = PENDING;
          tcnt_nxt  = TO_LOAD;
        end
      end
      PENDING: begin
        if (frame_start || tcnt == '0) state_nxt = COMMIT;
        else                           tcnt_nxt  = tcnt - TW'(1);
      end
      COMMIT: begin
        if (any_ev) begin
          state_nxt = PENDING;
          tcnt_nxt  = TO_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      deb         <= '0;
      deb_d       <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      shd_pat     <= 3'd0;
      shd_bri     <= 4'd15;
      shd_blank   <= 1'b0;
      state       <= IDLE;
      tcnt        <= '0;
      pattern_sel <= 3'd0;
      brightness  <= 4'd15;
      blank       <= 1'b0;
      cfg_update  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
      shd_pat    <= shd_pat_nxt;
      shd_bri    <= shd_bri_nxt;
      shd_blank  <= shd_blank_nxt;
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      cfg_update <= (state == COMMIT);
      if (state == COMMIT) begin
        pattern_sel <= shd_pat;
        brightness  <= shd_bri;
        blank       <= shd_blank;
      end
    end
  end

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Scoreboard bench for video_cfg_ctrl: button presses update a reference model,
// commits push expected outputs, and a monitor checks every cfg_update pulse.
module tb_video_cfg_ctrl;

  localparam int NP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       frame_start;
  logic [2:0] pattern_sel;
  logic [3:0] brightness;
  logic       blank;
  logic       cfg_update;
  logic       pending;

  video_cfg_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .FRAME_TIMEOUT  (100),
    .NUM_PATTERNS   (NP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .frame_start(frame_start),
    .pattern_sel(pattern_sel),
    .brightness (brightness),
    .blank      (blank),
    .cfg_update (cfg_update),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int bri;
    int blk;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_upd = 1'b0;

  // Shadow (s_*) and committed (c_*) model state
  int s_pat = 0, s_bri = 15, s_blk = 0;
  int c_pat = 0, c_bri = 15, c_blk = 0;
  bit model_pending = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cfg_update) begin
      tests++;
      if (prev_upd) begin
        fails++;
        $display("FAIL cfg_update_double at cycle %0d", cyc);
      end else if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cfg_update at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        if (pattern_sel !== 3'(mon_e.pat) || brightness !== 4'(mon_e.bri) ||
            blank !== 1'(mon_e.blk) || cyc != mon_e.due) begin
          fails++;
          $display("FAIL commit: got pat=%0d bri=%0d blank=%0b cycle=%0d, expected pat=%0d bri=%0d blank=%0d cycle=%0d",
                   pattern_sel, brightness, blank, cyc, mon_e.pat, mon_e.bri, mon_e.blk, mon_e.due);
        end
      end
    end
    prev_upd = cfg_update;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_pattern"}, 32'(pattern_sel), 32'(c_pat));
    check({tag, "_brightness"}, 32'(brightness), 32'(c_bri));
    check({tag, "_blank"}, 32'(blank), 32'(c_blk));
  endtask

  function automatic void apply(input logic [3:0] m);
    if (m[0] && m[1])  s_blk = 1 - s_blk;
    else if (m[0])     s_pat = (s_pat + 1) % NP;
    else if (m[1])     s_pat = (s_pat + NP - 1) % NP;
    if (m[2] && m[3])  s_bri = 8;
    else if (m[2])     s_bri = (s_bri < 15) ? s_bri + 1 : 15;
    else if (m[3])     s_bri = (s_bri > 0) ? s_bri - 1 : 0;
  endfunction

  // Hold the buttons, release, and let both edges settle through the debouncer.
  task automatic press(input logic [3:0] m, input bit expect_timeout);
    int d;
    @(negedge clk);
    btn = m;
    d = cyc;
    if (m != 4'd0) begin
      apply(m);
      model_pending = 1;
      if (expect_timeout) q.push_back('{s_pat, s_bri, s_blk, d + 107});
    end
    repeat (10) @(negedge clk);
    btn = 4'd0;
    repeat (10) @(negedge clk);
    check("pending_after_press", 32'(pending), 32'(model_pending));
    check_outputs("held");
  endtask

  task automatic commit();
    @(negedge clk);
    if (model_pending) q.push_back('{s_pat, s_bri, s_blk, cyc + 2});
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    c_pat = s_pat; c_bri = s_bri; c_blk = s_blk;
    model_pending = 0;
    check("pending_after_commit", 32'(pending), 32'd0);
    check_outputs("commit");
  endtask

  initial begin
    int d;
    int rise;
    logic [3:0] m;

    reset = 1'b1; btn = 4'd0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pattern", 32'(pattern_sel), 32'd0);
    check("rst_brightness", 32'(brightness), 32'd15);
    check("rst_blank", 32'(blank), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_cfg_update", 32'(cfg_update), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // frame_start while idle must not commit anything
    commit();

    // Bounce on btn[0], then a stable high
    for (int i = 0; i < 10; i++) begin
      btn[0] = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn[0] = 1'b1;
    d = cyc;
    rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      @(negedge clk);
      if (pending) rise = cyc;
    end
    check("bounce_event_time", 32'(rise), 32'(d + 7));
    apply(4'b0001);
    model_pending = 1;
    repeat (5) @(negedge clk);
    btn = 4'd0;
    repeat (10) @(negedge clk);
    check("bounce_pending", 32'(pending), 32'd1);
    check_outputs("bounce_held");
    commit();

    // Wrap and saturate
    press(4'b0010, 0); commit();
    press(4'b0010, 0); commit();
    check("wrap_to_7", 32'(pattern_sel), 32'd7);
    press(4'b0100, 0); commit();
    check("sat_15", 32'(brightness), 32'd15);
    for (int i = 0; i < 16; i++) begin
      press(4'b1000, 0); commit();
    end
    check("sat_0", 32'(brightness), 32'd0);

    // Simultaneous presses
    press(4'b0011, 0); commit();
    check("blank_toggle", 32'(blank), 32'd1);
    press(4'b1100, 0); commit();
    check("bri_mid", 32'(brightness), 32'd8);

    // Timeout commit without frame_start
    press(4'b0001, 1);
    repeat (100) @(negedge clk);
    c_pat = s_pat; c_bri = s_bri; c_blk = s_blk;
    model_pending = 0;
    check("timeout_pending", 32'(pending), 32'd0);
    check_outputs("timeout");

    // Random presses
    for (int i = 0; i < 12; i++) begin
      m = 4'($urandom_range(0, 15));
      press(m, 0);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      commit();
    end

    // Reset while pending discards the change
    press(4'b0101, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s_pat = 0; s_bri = 15; s_blk = 0;
    c_pat = 0; c_bri = 15; c_blk = 0;
    model_pending = 0;
    check("midrst_pending", 32'(pending), 32'd0);
    check_outputs("midrst");
    commit();
    press(4'b0001, 0); commit();
    check("post_rst_pattern", 32'(pattern_sel), 32'd1);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
